// File: rtl/ripple_pkg.sv
// Shared constants and a plain-arithmetic reference for the ripple-carry adder.
package ripple_pkg;

  localparam int RIPPLE_DEF_WIDTH = 4;

  // Returns {cout,sum} with cout at bit position 'width'; operands are assumed pre-masked.
  function automatic logic [32:0] ref_add(input int unsigned width,
                                          input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic cin);
    logic [32:0] total;
    total = {1'b0, a} + {1'b0, b} + {32'b0, cin};
    return total & ((33'd1 << (width + 1)) - 33'd1);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder; the leaf cell chained by ripple_adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/ripple_adder.sv
// WIDTH-bit ripple-carry adder with a registered result and valid strobe.
// Define RIPPLE_OVF_EN to add the registered signed-overflow output ovf.
module ripple_adder
  import ripple_pkg::*;
#(
  parameter int WIDTH = RIPPLE_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef RIPPLE_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  logic             valid_q;
  logic [WIDTH-1:0] sum_q,  sum_d;
  logic             cout_q, cout_d;

  assign c[0] = cin;

  // Each stage sees only its neighbour's carry, so the carry ripples bit to bit.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
      full_adder u_fa (
        .a  (a[gi]),
        .b  (b[gi]),
        .ci (c[gi]),
        .s  (s[gi]),
        .co (c[gi+1])
      );
    end
  endgenerate

  always_comb begin
    sum_d  = sum_q;
    cout_d = cout_q;
    if (in_valid) begin
      sum_d  = s;
      cout_d = c[WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      valid_q <= in_valid;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign out_valid = valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

`ifdef RIPPLE_OVF_EN
  logic ovf_q, ovf_d;

  // Carries into and out of the sign bit disagree exactly on two's-complement overflow.
  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) begin
      ovf_d = c[WIDTH] ^ c[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_ripple_adder.sv
// Self-checking bench for ripple_adder at WIDTH=1, 4 and 8 (with or without RIPPLE_OVF_EN).
module tb_ripple_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin1 = 1'b0, cin4 = 1'b0, cin8 = 1'b0;

  logic       ov1, ov4, ov8;
  logic [0:0] s1;
  logic [3:0] s4;
  logic [7:0] s8;
  logic       co1, co4, co8;
`ifdef RIPPLE_OVF_EN
  logic       of1, of4, of8;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ripple_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a1), .b(b1), .cin(cin1),
    .out_valid(ov1), .sum(s1), .cout(co1)
`ifdef RIPPLE_OVF_EN
    , .ovf(of1)
`endif
  );

  ripple_adder #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a4), .b(b4), .cin(cin4),
    .out_valid(ov4), .sum(s4), .cout(co4)
`ifdef RIPPLE_OVF_EN
    , .ovf(of4)
`endif
  );

  ripple_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8), .b(b8), .cin(cin8),
    .out_valid(ov8), .sum(s8), .cout(co8)
`ifdef RIPPLE_OVF_EN
    , .ovf(of8)
`endif
  );

  // Reference: integer addition, then signed-range test for overflow. Result {ovf,cout,sum[7:0]}.
  function automatic logic [9:0] model(int w, int unsigned a, int unsigned b, bit cin);
    int unsigned tot;
    int          sa, sb, r;
    bit          ov;
    tot = a + b + cin;
    sa  = (a >= (1 << (w - 1))) ? int'(a) - (1 << w) : int'(a);
    sb  = (b >= (1 << (w - 1))) ? int'(b) - (1 << w) : int'(b);
    r   = sa + sb + int'(cin);
    ov  = (r > (1 << (w - 1)) - 1) || (r < -(1 << (w - 1)));
    return {ov, 1'(tot >> w), 8'(tot % (1 << w))};
  endfunction

  task automatic test_reset();
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({ov1, s1, co1} !== 3'b000) begin
      errors++; $display("FAIL reset_w1: got v/s/c=%b%b%b want 000", ov1, s1, co1);
    end
    checks++;
    if ({ov4, s4, co4} !== 6'b0) begin
      errors++; $display("FAIL reset_w4: got v=%b s=%h c=%b want 0/0/0", ov4, s4, co4);
    end
    checks++;
    if ({ov8, s8, co8} !== 10'b0) begin
      errors++; $display("FAIL reset_w8: got v=%b s=%h c=%b want 0/0/0", ov8, s8, co8);
    end
`ifdef RIPPLE_OVF_EN
    checks++;
    if ({of1, of4, of8} !== 3'b000) begin
      errors++; $display("FAIL reset_ovf: got %b%b%b want 000", of1, of4, of8);
    end
`endif
    $display("reset: outputs checked while rst_n=0");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [3:0] ta [6] = '{4'hF, 4'h0, 4'h0, 4'h7, 4'hF, 4'h8};
    logic [3:0] tb [6] = '{4'hF, 4'h0, 4'h0, 4'h1, 4'h1, 4'h8};
    logic       tc [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0] es [6] = '{4'hF, 4'h0, 4'h1, 4'h8, 4'h0, 4'h0};
    logic       ec [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       eo [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a4 = ta[i]; b4 = tb[i]; cin4 = tc[i];
      @(posedge clk); #1;
      checks++;
      if (ov4 !== 1'b1 || s4 !== es[i] || co4 !== ec[i]) begin
        errors++;
        $display("FAIL directed_%0d: got v=%b s=%h c=%b want v=1 s=%h c=%b",
                 i, ov4, s4, co4, es[i], ec[i]);
      end
`ifdef RIPPLE_OVF_EN
      checks++;
      if (of4 !== eo[i]) begin
        errors++; $display("FAIL directed_ovf_%0d: got %b want %b", i, of4, eo[i]);
      end
`endif
      $display("directed %0d: a=%h b=%h cin=%b -> s=%h c=%b (ovf model %b)",
               i, ta[i], tb[i], tc[i], s4, co4, eo[i]);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    in_valid = 1'b1; a4 = 4'h9; b4 = 4'h9; cin4 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ov4 !== 1'b1 || s4 !== 4'h3 || co4 !== 1'b1) begin
      errors++; $display("FAIL async_pre: got v=%b s=%h c=%b want 1/3/1", ov4, s4, co4);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ov4 !== 1'b0 || s4 !== 4'h0 || co4 !== 1'b0) begin
      errors++; $display("FAIL async_clear: got v=%b s=%h c=%b want 0/0/0", ov4, s4, co4);
    end
`ifdef RIPPLE_OVF_EN
    checks++;
    if (of4 !== 1'b0) begin
      errors++; $display("FAIL async_clear_ovf: got %b want 0", of4);
    end
`endif
    $display("async reset: mid-cycle assertion cleared outputs to s=%h c=%b v=%b", s4, co4, ov4);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_hold();
    @(negedge clk);
    in_valid = 1'b1; a4 = 4'h5; b4 = 4'h6; cin4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b0; a4 = 4'($urandom); b4 = 'x; cin4 = 1'bx;
      @(posedge clk); #1;
      checks++;
      if (ov4 !== 1'b0 || s4 !== 4'hB || co4 !== 1'b0) begin
        errors++; $display("FAIL hold_%0d: got v=%b s=%h c=%b want 0/b/0", i, ov4, s4, co4);
      end
`ifdef RIPPLE_OVF_EN
      checks++;
      if (of4 !== 1'b1) begin
        errors++; $display("FAIL hold_ovf_%0d: got %b want 1", i, of4);
      end
`endif
      $display("hold %0d: in_valid=0 -> s=%h c=%b v=%b", i, s4, co4, ov4);
    end
  endtask

  task automatic test_random();
    logic [9:0] e1, e4, e8, r1, r4, r8;
    logic       ev;
    int         bad;
    e1 = '0; e4 = '0; e8 = '0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      in_valid = (i == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
      a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      ev = in_valid;
      r1 = model(1, a1, b1, cin1);
      r4 = model(4, a4, b4, cin4);
      r8 = model(8, a8, b8, cin8);
      if (in_valid) begin
        e1 = r1; e4 = r4; e8 = r8;
      end
      @(posedge clk); #1;
      bad = 0;
      checks++;
      if (ov1 !== ev || s1 !== e1[0:0] || co1 !== e1[8]) begin
        errors++; bad++;
        $display("FAIL rand_w1_%0d: got v=%b s=%h c=%b want v=%b s=%h c=%b",
                 i, ov1, s1, co1, ev, e1[0:0], e1[8]);
      end
      checks++;
      if (ov4 !== ev || s4 !== e4[3:0] || co4 !== e4[8]) begin
        errors++; bad++;
        $display("FAIL rand_w4_%0d: got v=%b s=%h c=%b want v=%b s=%h c=%b",
                 i, ov4, s4, co4, ev, e4[3:0], e4[8]);
      end
      checks++;
      if (ov8 !== ev || s8 !== e8[7:0] || co8 !== e8[8]) begin
        errors++; bad++;
        $display("FAIL rand_w8_%0d: got v=%b s=%h c=%b want v=%b s=%h c=%b",
                 i, ov8, s8, co8, ev, e8[7:0], e8[8]);
      end
`ifdef RIPPLE_OVF_EN
      checks++;
      if ({of1, of4, of8} !== {e1[9], e4[9], e8[9]}) begin
        errors++; bad++;
        $display("FAIL rand_ovf_%0d: got %b%b%b want %b%b%b",
                 i, of1, of4, of8, e1[9], e4[9], e8[9]);
      end
`endif
      $display("rand %0d: iv=%b w1 s=%h c=%b | w4 s=%h c=%b | w8 s=%h c=%b | mismatches=%0d",
               i, ev, s1, co1, s4, co4, s8, co8, bad);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_async_reset();
    test_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
